// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-buffer definitions: character width, default depth and
// almost-full threshold, plus the helper that sizes the occupancy counter.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W   = 8;  // one UART character
  localparam int FIFO_DEPTH    = 8;  // default buffer depth, power of two
  localparam int AF_THRESH_DEF = 6;  // default almost-full level

  // Occupancy must represent 0..depth inclusive, hence one bit over the pointer.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receive buffer and its neighbours.
// master: the side that feeds bytes in and consumes them (receiver/consumer).
// slave : the buffer itself.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = FIFO_DEPTH
);

  localparam int CW = count_w(DEPTH);

  logic             ena;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             almost_full;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output ena, wr_data, wr_valid, rd_ready, clr_overrun,
    input  rd_data, rd_valid, count, full, almost_full, overrun
  );

  modport slave (
    input  ena, wr_data, wr_valid, rd_ready, clr_overrun,
    output rd_data, rd_valid, count, full, almost_full, overrun
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// Flop-array storage for the receive buffer: one synchronous write port and
// one asynchronous read port so the head byte falls through with no latency.
module uart_fifo_ram
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  // NOTE: storage has no reset; validity is tracked by the pointers and count,
  // so clearing it would only add reset fan-out. Non-blocking keeps the write
  // ordered against the pointer update in the same edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver. Captures one-cycle valid
// pulses, holds up to DEPTH bytes and presents them first-word-fall-through.
// Reports occupancy, almost-full and a sticky overrun flag for dropped bytes.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH     = UART_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input logic            clk,
  input logic            rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overrun_q;
  logic [WIDTH-1:0] head;
  logic             full_w;
  logic             rd_valid_w;
  logic             push;
  logic             pop;
  logic             drop;

  // Flags come only from registered occupancy, so rd_ready cannot glitch them.
  assign full_w     = (count_q == DEPTH_C);
  assign rd_valid_w = bus.ena & (count_q != '0);

  // A pop frees a slot in the same cycle, so a full buffer still accepts a
  // byte that arrives alongside a read.
  assign pop  = rd_valid_w & bus.rd_ready;
  assign push = bus.ena & bus.wr_valid & (~full_w | pop);
  assign drop = bus.ena & bus.wr_valid & ~push;

  uart_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Advance pointers and occupancy on accepted push/pop; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overrun: a dropped byte sets it and beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (drop) begin
      overrun_q <= 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.rd_valid    = rd_valid_w;
  assign bus.rd_data     = rd_valid_w ? head : '0;
  assign bus.count       = count_q;
  assign bus.full        = full_w;
  assign bus.almost_full = (count_q >= AF_C);
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model checked
// every cycle, a table of directed vectors, and hand-written corner sequences.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  uart_rx_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the buffer is just an ordered queue of bytes.
  logic [W-1:0] mq [$];
  logic         m_ovr;

  typedef struct {
    logic         ena;
    logic         wv;
    logic [W-1:0] wd;
    logic         rr;
    logic         clr;
    int           cnt;
    logic         rv;
    logic [W-1:0] rd;
    logic         full;
    logic         af;
    logic         ovr;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic wv, input logic [W-1:0] wd,
                       input logic rr, input logic clr, input logic r);
    bus.ena         = e;
    bus.wr_valid    = wv;
    bus.wr_data     = wd;
    bus.rd_ready    = rr;
    bus.clr_overrun = clr;
    rst             = r;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare all outputs with what the queue model implies for current inputs.
  task automatic compare_model();
    logic ev;
    ev = bus.ena && (mq.size() != 0);
    check("rd_valid",    32'(bus.rd_valid),    32'(ev));
    check("rd_data",     32'(bus.rd_data),     ev ? 32'(mq[0]) : 32'h0);
    check("count",       32'(bus.count),       32'(mq.size()));
    check("full",        32'(bus.full),        32'(mq.size() == D));
    check("almost_full", 32'(bus.almost_full), 32'(mq.size() >= AF));
    check("overrun",     32'(bus.overrun),     32'(m_ovr));
  endtask

  // Apply the buffer rules to the model for one clock edge.
  task automatic model_edge();
    bit do_pop;
    bit do_push;
    if (rst) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      do_pop  = bus.ena && (mq.size() > 0) && bus.rd_ready;
      do_push = bus.ena && bus.wr_valid && ((mq.size() < D) || do_pop);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(bus.wr_data);
      if (bus.ena && bus.wr_valid && !do_push) m_ovr = 1'b1;
      else if (bus.clr_overrun)               m_ovr = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic void add(input logic e, input logic wv, input logic [W-1:0] wd,
                              input logic rr, input logic clr, input int cnt,
                              input logic [W-1:0] rd, input logic ovr);
    vec_t v;
    v.ena = e; v.wv = wv; v.wd = wd; v.rr = rr; v.clr = clr;
    v.cnt = cnt; v.rv = (cnt != 0); v.rd = (cnt != 0) ? rd : '0;
    v.full = (cnt == D); v.af = (cnt >= AF); v.ovr = ovr;
    tbl.push_back(v);
  endfunction

  logic [W-1:0] seq2 [3] = '{8'h55, 8'hA3, 8'h0F};
  logic [W-1:0] heads [7] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};

  initial begin
    // Directed vectors, each observed one edge later with ena=1 and no traffic.
    for (int i = 1; i <= 8; i++) add(1, 1, W'(i), 0, 0, i, 8'h01, 0);
    add(1, 1, 8'h09, 0, 0, 8, 8'h01, 1);   // ninth byte dropped
    add(1, 0, 8'h00, 0, 1, 8, 8'h01, 0);   // clear overrun
    add(1, 1, 8'h99, 1, 0, 8, 8'h02, 0);   // push+pop while full
    add(0, 1, 8'hAA, 1, 0, 8, 8'h02, 0);   // disabled: everything ignored
    add(1, 1, 8'hAB, 0, 1, 8, 8'h02, 1);   // set beats clear
    for (int i = 0; i < 7; i++) add(1, 0, 8'h00, 1, 0, 7 - i, heads[i], 1);
    add(1, 0, 8'h00, 1, 0, 0, 8'h00, 1);   // drain last byte
    add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0);
    add(1, 1, 8'h5A, 1, 0, 1, 8'h5A, 0);   // push+pop while empty
    add(1, 0, 8'h00, 1, 0, 0, 8'h00, 0);

    // Reset and idle.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    m_ovr = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
    cycle();
    idle();
    cycle();

    // Reset mid-fill discards stored bytes.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, W'(8'hC0 + i), 0, 0, 0);
      cycle();
    end
    idle();
    #1;
    check("fill_count", 32'(bus.count), 32'd3);
    drive(1, 1, 8'hEE, 1, 0, 1);
    cycle();
    idle();
    #1;
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Gapped pushes with the consumer always ready.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, seq2[i], 1, 0, 0);
      cycle();
      drive(1, 0, '0, 1, 0, 0);
      #1;
      check("ffwt_valid", 32'(bus.rd_valid), 32'd1);
      check("ffwt_data",  32'(bus.rd_data),  32'(seq2[i]));
      cycle();
      cycle();
    end
    idle();
    cycle();

    // Table vectors.
    foreach (tbl[k]) begin
      drive(tbl[k].ena, tbl[k].wv, tbl[k].wd, tbl[k].rr, tbl[k].clr, 0);
      cycle();
      idle();
      #1;
      check("tbl_count",   32'(bus.count),       32'(tbl[k].cnt));
      check("tbl_valid",   32'(bus.rd_valid),    32'(tbl[k].rv));
      check("tbl_data",    32'(bus.rd_data),     32'(tbl[k].rd));
      check("tbl_full",    32'(bus.full),        32'(tbl[k].full));
      check("tbl_af",      32'(bus.almost_full), 32'(tbl[k].af));
      check("tbl_overrun", 32'(bus.overrun),     32'(tbl[k].ovr));
    end

    // Pointer wrap: twenty push/pop pairs two bytes at a time.
    for (int i = 0; i < 20; i += 2) begin
      drive(1, 1, W'(8'h10 + i), 0, 0, 0);
      cycle();
      drive(1, 1, W'(8'h11 + i), 0, 0, 0);
      cycle();
      for (int j = 0; j < 2; j++) begin
        drive(1, 0, '0, 1, 0, 0);
        #1;
        check("wrap_data", 32'(bus.rd_data), 32'(8'h10 + i + j));
        cycle();
      end
    end
    idle();
    #1;
    check("wrap_empty", 32'(bus.count), 32'd0);

    // Randomised traffic with phases of slow and fast reading.
    for (int c = 0; c < 3000; c++) begin
      logic rd_bias;
      rd_bias = ((c / 200) % 2) == 0;
      drive($urandom_range(0, 9) != 0,
            $urandom_range(0, 1) == 1,
            W'($urandom),
            rd_bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 299) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
